// File: rtl/fp_normalize_round.sv
// fp_normalize_round
//   Post-add/sub stage. It accepts the raw sign, the biased exponent and the
//   extended mantissa {carry, hidden, fraction, G, R, S}. It normalises the
//   mantissa one bit per cycle and rounds it to nearest-even. It then packs an
//   IEEE-754 word with overflow/underflow/inexact flags. Only one operation is
//   in flight at a time.
//
// Ports
//   clk, rst_n       clock and synchronous active-low reset
//   in_valid/ready   input handshake; in_ready is high only while idle
//   in_sign          result sign
//   in_exp           biased exponent of the larger operand (0 is taken as 1)
//   in_mant          {carry, hidden, fraction, G, R, S}
//   in_special       bypass request: in_special_val becomes the result
//   in_special_val   pre-formed NaN/Inf word from upstream
//   out_valid/ready  output handshake; the result is held until accepted
//   out_result       packed {sign, exponent field, fraction}
//   out_overflow     result rounded to +/-Inf
//   out_underflow    result is subnormal or zero and inexact
//   out_inexact      any of G/R/S was set after normalisation
module fp_normalize_round #(
  parameter int FRACTION = 23,
  parameter int EXPONENT = 8,
  localparam int W = FRACTION + 5,
  localparam int N = 1 + EXPONENT + FRACTION
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXPONENT-1:0] in_exp,
  input  logic [W-1:0]        in_mant,
  input  logic                in_special,
  input  logic [N-1:0]        in_special_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_result,
  output logic                out_overflow,
  output logic                out_underflow,
  output logic                out_inexact
);

  // The exponent carries two spare bits and is signed, so the +1 steps near
  // the top and the -1 steps near the bottom can never wrap around.
  localparam logic signed [EXPONENT+1:0] EXP_ONE = (EXPONENT+2)'(1);
  localparam logic signed [EXPONENT+1:0] EXP_MAX = (EXPONENT+2)'((1 << EXPONENT) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} stateT;

  stateT                     state;
  stateT                     nextState;
  logic                      signReg;
  logic signed [EXPONENT+1:0] expReg;
  logic [W-1:0]              mantReg;
  logic [N-1:0]              resultReg;
  logic                      overflowReg;
  logic                      underflowReg;
  logic                      inexactReg;

  logic                      carryBit;
  logic                      normStop;
  logic                      roundUp;
  logic                      inexactNow;
  logic [FRACTION+1:0]       sumVec;
  logic [FRACTION:0]         roundMant;
  logic signed [EXPONENT+1:0] roundExp;
  logic [N-1:0]              rndResult;
  logic                      rndOverflow;
  logic                      rndUnderflow;
  logic                      rndInexact;

  assign carryBit = mantReg[W-1];

  // Left shifting stops when the hidden bit is set, when there is nothing
  // left to shift, or when the exponent has reached the subnormal floor.
  assign normStop = mantReg[W-2] || (mantReg == '0) || (expReg <= EXP_ONE);

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_result    = resultReg;
  assign out_overflow  = overflowReg;
  assign out_underflow = underflowReg;
  assign out_inexact   = inexactReg;

  // Next-state logic. A carry needs one right shift and then rounding. A
  // mantissa that is already normalised (or cannot be) goes straight to
  // rounding. Otherwise NORM loops on itself one left shift per cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = in_special ? DONE : NORM;
      NORM:    if (carryBit || normStop) nextState = ROUND;
      ROUND:   nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Rounding and packing, evaluated on the normalised mantissa. Rounding is
  // round-to-nearest-even on {hidden, fraction}. An increment that ripples
  // into the carry position is renormalised with one right shift. The bit
  // shifted out is always zero in that case. Zero is checked first so that
  // a zero mantissa always packs as +0 with no flags, whatever the exponent.
  always_comb begin
    roundUp      = mantReg[2] & (mantReg[1] | mantReg[0] | mantReg[3]);
    inexactNow   = mantReg[2] | mantReg[1] | mantReg[0];
    sumVec       = mantReg[W-1:3] + {{(FRACTION+1){1'b0}}, roundUp};
    roundMant    = sumVec[FRACTION:0];
    roundExp     = expReg;
    rndResult    = '0;
    rndOverflow  = 1'b0;
    rndUnderflow = 1'b0;
    rndInexact   = 1'b0;
    if (sumVec[FRACTION+1]) begin
      roundMant = sumVec[FRACTION+1:1];
      roundExp  = expReg + EXP_ONE;
    end
    if (mantReg == '0) begin
      rndResult = '0;
    end else if (roundExp >= EXP_MAX) begin
      rndResult   = {signReg, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
      rndOverflow = 1'b1;
      rndInexact  = 1'b1;
    end else if (!roundMant[FRACTION]) begin
      rndResult    = {signReg, {EXPONENT{1'b0}}, roundMant[FRACTION-1:0]};
      rndUnderflow = inexactNow;
      rndInexact   = inexactNow;
    end else begin
      rndResult  = {signReg, roundExp[EXPONENT-1:0], roundMant[FRACTION-1:0]};
      rndInexact = inexactNow;
    end
  end

  // State and datapath registers. A reset at any point abandons the current
  // operation and clears all outputs. In NORM a right shift folds the
  // discarded R and S bits into the new sticky bit. A left shift fills
  // with zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      signReg      <= 1'b0;
      expReg       <= '0;
      mantReg      <= '0;
      resultReg    <= '0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
      inexactReg   <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (in_valid) begin
            signReg <= in_sign;
            expReg  <= (in_exp == '0) ? EXP_ONE : {2'b00, in_exp};
            mantReg <= in_mant;
            if (in_special) begin
              resultReg    <= in_special_val;
              overflowReg  <= 1'b0;
              underflowReg <= 1'b0;
              inexactReg   <= 1'b0;
            end
          end
        end
        NORM: begin
          if (carryBit) begin
            mantReg <= {1'b0, mantReg[W-1:2], mantReg[1] | mantReg[0]};
            expReg  <= expReg + EXP_ONE;
          end else if (!normStop) begin
            mantReg <= {mantReg[W-2:0], 1'b0};
            expReg  <= expReg - EXP_ONE;
          end
        end
        ROUND: begin
          resultReg    <= rndResult;
          overflowReg  <= rndOverflow;
          underflowReg <= rndUnderflow;
          inexactReg   <= rndInexact;
        end
        default: ;
      endcase
    end
  end

endmodule
